// File: rtl/cpu_defs_pkg.sv
// Shared definitions for the execute stage: opcodes, FSM states and immediate helpers.
package cpu_defs_pkg;

  localparam logic [4:0] OP_SLL   = 5'd1;
  localparam logic [4:0] OP_ADDI  = 5'd2;
  localparam logic [4:0] OP_MUL   = 5'd3;
  localparam logic [4:0] OP_MOVE  = 5'd4;
  localparam logic [4:0] OP_MOVEI = 5'd5;
  localparam logic [4:0] OP_ADD   = 5'd6;
  localparam logic [4:0] OP_LW    = 5'd9;
  localparam logic [4:0] OP_SW    = 5'd10;
  localparam logic [4:0] OP_HALT  = 5'd12;
  localparam logic [4:0] OP_MULI  = 5'd13;
  localparam logic [4:0] OP_JAL   = 5'd14;
  localparam logic [4:0] OP_ORI   = 5'd15;
  localparam logic [4:0] OP_LUI   = 5'd16;

  // Widest datapath the helpers cover; callers size-cast the result down to XLEN.
  localparam int MAX_XLEN = 64;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_MEM,
    ST_HALT
  } state_t;

  function automatic logic [MAX_XLEN-1:0] sext16(input logic [15:0] v);
    return {{(MAX_XLEN-16){v[15]}}, v};
  endfunction

  function automatic logic [MAX_XLEN-1:0] zext16(input logic [15:0] v);
    return {{(MAX_XLEN-16){1'b0}}, v};
  endfunction

endpackage

// File: rtl/execute_unit_iter_mul.sv
// Iterative shift-add multiplier: retires MUL_BITS multiplier bits per cycle and
// produces the low XLEN bits of a*b after XLEN/MUL_BITS steps.
module iter_mul #(
  parameter int XLEN     = 32,
  parameter int MUL_BITS = 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] product
);

  localparam int STEPS = XLEN / MUL_BITS;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

  logic [CW-1:0]   step_cnt;
  logic [XLEN-1:0] acc;
  logic [XLEN-1:0] a_sh;
  logic [XLEN-1:0] b_sh;
  logic [XLEN-1:0] b_chunk;
  logic [XLEN-1:0] partial;

  // Low MUL_BITS of the remaining multiplier select how much of the shifted multiplicand to add.
  assign b_chunk = XLEN'(b_sh[MUL_BITS-1:0]);
  assign partial = a_sh * b_chunk;

  // The final step's sum is presented combinationally so the caller can capture it on the done cycle.
  assign product = acc + partial;
  assign done    = busy && (step_cnt == '0);

  // Load operands on start, then accumulate one chunk per cycle while counting steps down to zero.
  always_ff @(posedge clock) begin
    if (reset) begin
      busy     <= 1'b0;
      step_cnt <= '0;
      acc      <= '0;
      a_sh     <= '0;
      b_sh     <= '0;
    end else if (start) begin
      busy     <= 1'b1;
      step_cnt <= CW'(STEPS - 1);
      acc      <= '0;
      a_sh     <= a;
      b_sh     <= b;
    end else if (busy) begin
      acc  <= product;
      a_sh <= a_sh << MUL_BITS;
      b_sh <= b_sh >> MUL_BITS;
      if (step_cnt == '0) begin
        busy <= 1'b0;
      end else begin
        step_cnt <= step_cnt - CW'(1);
      end
    end
  end

endmodule

// File: rtl/execute_unit.sv
// Execute stage: single-cycle ALU ops, iterative multiply, req/ack data-memory
// access, retired-instruction counting and halt.
module execute_unit
  import cpu_defs_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int REG_AW   = 5,
  parameter int MUL_BITS = 1,
  parameter int CNT_W    = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_op,
  input  logic [XLEN-1:0]   in_src1,
  input  logic [XLEN-1:0]   in_src2,
  input  logic [REG_AW-1:0] in_dst,
  input  logic [15:0]       in_imm,
  output logic              wb_valid,
  output logic [REG_AW-1:0] wb_dst,
  output logic [XLEN-1:0]   wb_data,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [XLEN-1:0]   dmem_addr,
  output logic [XLEN-1:0]   dmem_wdata,
  input  logic              dmem_ack,
  input  logic [XLEN-1:0]   dmem_rdata,
  output logic              halted,
  output logic [CNT_W-1:0]  instr_count
);

  state_t            state;
  logic [REG_AW-1:0] pend_dst;

  logic [XLEN-1:0]   imm_sext;
  logic [XLEN-1:0]   imm_zext;
  logic [XLEN-1:0]   alu_result;
  logic              alu_wb;
  logic              alu_counted;

  logic              mul_start;
  logic [XLEN-1:0]   mul_b;
  logic              mul_busy;
  logic              mul_done;
  logic [XLEN-1:0]   mul_product;

  assign in_ready = (state == ST_IDLE);

  assign imm_sext = XLEN'(sext16(in_imm));
  assign imm_zext = XLEN'(zext16(in_imm));

  // Multiplies start on the accept edge; a reset on that same edge wins inside the multiplier.
  assign mul_start = in_valid && in_ready && ((in_op == OP_MUL) || (in_op == OP_MULI));
  assign mul_b     = (in_op == OP_MULI) ? imm_sext : in_src2;

  iter_mul #(
    .XLEN     (XLEN),
    .MUL_BITS (MUL_BITS)
  ) u_mul (
    .clock   (clock),
    .reset   (reset),
    .start   (mul_start),
    .a       (in_src1),
    .b       (mul_b),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );

  // Decode single-cycle results and whether they write back and count as retired work.
  always_comb begin
    alu_result  = '0;
    alu_wb      = 1'b0;
    alu_counted = 1'b0;
    case (in_op)
      OP_SLL: begin
        alu_result  = in_src2 << in_imm[4:0];
        alu_wb      = 1'b1;
        alu_counted = !((in_src2 == '0) && (in_imm == 16'd0));
      end
      OP_ADDI: begin
        alu_result  = in_src1 + imm_sext;
        alu_wb      = 1'b1;
        alu_counted = 1'b1;
      end
      OP_MOVE: begin
        alu_result  = in_src1;
        alu_wb      = 1'b1;
        alu_counted = 1'b1;
      end
      OP_MOVEI: begin
        alu_result  = imm_sext;
        alu_wb      = 1'b1;
        alu_counted = 1'b1;
      end
      OP_ADD: begin
        alu_result  = in_src1 + in_src2;
        alu_wb      = 1'b1;
        alu_counted = 1'b1;
      end
      OP_JAL: begin
        alu_result  = imm_zext;
        alu_wb      = 1'b1;
        alu_counted = 1'b1;
      end
      OP_ORI: begin
        alu_result  = in_src1 | imm_zext;
        alu_wb      = 1'b1;
        alu_counted = 1'b1;
      end
      OP_LUI: begin
        alu_result  = imm_zext << 16;
        alu_wb      = 1'b1;
        alu_counted = 1'b1;
      end
      OP_HALT: begin
        alu_counted = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Main FSM with registered writeback, memory port, halt flag and retired counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ST_IDLE;
      pend_dst    <= '0;
      wb_valid    <= 1'b0;
      wb_dst      <= '0;
      wb_data     <= '0;
      dmem_req    <= 1'b0;
      dmem_we     <= 1'b0;
      dmem_addr   <= '0;
      dmem_wdata  <= '0;
      halted      <= 1'b0;
      instr_count <= '0;
    end else begin
      wb_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            if (alu_wb) begin
              wb_valid <= 1'b1;
              wb_dst   <= in_dst;
              wb_data  <= alu_result;
            end
            if (alu_counted) begin
              instr_count <= instr_count + CNT_W'(1);
            end
            case (in_op)
              OP_MUL, OP_MULI: begin
                state    <= ST_MUL;
                pend_dst <= in_dst;
              end
              OP_LW, OP_SW: begin
                state      <= ST_MEM;
                pend_dst   <= in_dst;
                dmem_req   <= 1'b1;
                dmem_we    <= (in_op == OP_SW);
                dmem_addr  <= in_src1 + imm_sext;
                dmem_wdata <= in_src2;
              end
              OP_HALT: begin
                state  <= ST_HALT;
                halted <= 1'b1;
              end
              default: begin
              end
            endcase
          end
        end
        ST_MUL: begin
          if (mul_done) begin
            state       <= ST_IDLE;
            wb_valid    <= 1'b1;
            wb_dst      <= pend_dst;
            wb_data     <= mul_product;
            instr_count <= instr_count + CNT_W'(1);
          end else if (!mul_busy) begin
            state <= ST_IDLE;
          end
        end
        ST_MEM: begin
          if (dmem_ack) begin
            state       <= ST_IDLE;
            dmem_req    <= 1'b0;
            instr_count <= instr_count + CNT_W'(1);
            if (!dmem_we) begin
              wb_valid <= 1'b1;
              wb_dst   <= pend_dst;
              wb_data  <= dmem_rdata;
            end
          end
        end
        ST_HALT: begin
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_execute_unit.sv
// Directed self-checking bench for execute_unit (XLEN=32, MUL_BITS=1 and 4).
module tb_execute_unit;
  import cpu_defs_pkg::*;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;
  localparam int CNT_W  = 32;

  logic              clock;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [4:0]        in_op;
  logic [XLEN-1:0]   in_src1;
  logic [XLEN-1:0]   in_src2;
  logic [REG_AW-1:0] in_dst;
  logic [15:0]       in_imm;
  logic              wb_valid;
  logic [REG_AW-1:0] wb_dst;
  logic [XLEN-1:0]   wb_data;
  logic              dmem_req;
  logic              dmem_we;
  logic [XLEN-1:0]   dmem_addr;
  logic [XLEN-1:0]   dmem_wdata;
  logic              dmem_ack;
  logic [XLEN-1:0]   dmem_rdata;
  logic              halted;
  logic [CNT_W-1:0]  instr_count;

  logic              in_valid4;
  logic              in_ready4;
  logic              wb_valid4;
  logic [REG_AW-1:0] wb_dst4;
  logic [XLEN-1:0]   wb_data4;
  logic              dmem_req4;
  logic              dmem_we4;
  logic [XLEN-1:0]   dmem_addr4;
  logic [XLEN-1:0]   dmem_wdata4;
  logic              dmem_ack4;
  logic              halted4;
  logic [CNT_W-1:0]  instr_count4;

  int checks;
  int errors;

  execute_unit #(.XLEN(XLEN), .REG_AW(REG_AW), .MUL_BITS(1), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_src1(in_src1), .in_src2(in_src2), .in_dst(in_dst), .in_imm(in_imm),
    .wb_valid(wb_valid), .wb_dst(wb_dst), .wb_data(wb_data),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .halted(halted), .instr_count(instr_count)
  );

  execute_unit #(.XLEN(XLEN), .REG_AW(REG_AW), .MUL_BITS(4), .CNT_W(CNT_W)) dut4 (
    .clock(clock), .reset(reset), .in_valid(in_valid4), .in_ready(in_ready4),
    .in_op(in_op), .in_src1(in_src1), .in_src2(in_src2), .in_dst(in_dst), .in_imm(in_imm),
    .wb_valid(wb_valid4), .wb_dst(wb_dst4), .wb_data(wb_data4),
    .dmem_req(dmem_req4), .dmem_we(dmem_we4), .dmem_addr(dmem_addr4), .dmem_wdata(dmem_wdata4),
    .dmem_ack(dmem_ack4), .dmem_rdata(dmem_rdata), .halted(halted4), .instr_count(instr_count4)
  );

  // Free-running clock, 10 time units per cycle.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Hard stop in case something hangs outside the bounded waits.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Presents one instruction for exactly one edge, then returns #1 after that edge.
  task automatic applyStimulus(input logic [4:0] op, input logic [XLEN-1:0] s1, input logic [XLEN-1:0] s2,
                               input logic [REG_AW-1:0] dst, input logic [15:0] imm);
    in_op    = op;
    in_src1  = s1;
    in_src2  = s2;
    in_dst   = dst;
    in_imm   = imm;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    checkOutput({tag, "_wb_valid"}, 64'(wb_valid), 64'd0);
    checkOutput({tag, "_wb_dst"}, 64'(wb_dst), 64'd0);
    checkOutput({tag, "_wb_data"}, 64'(wb_data), 64'd0);
    checkOutput({tag, "_dmem_req"}, 64'(dmem_req), 64'd0);
    checkOutput({tag, "_dmem_we"}, 64'(dmem_we), 64'd0);
    checkOutput({tag, "_dmem_addr"}, 64'(dmem_addr), 64'd0);
    checkOutput({tag, "_dmem_wdata"}, 64'(dmem_wdata), 64'd0);
    checkOutput({tag, "_halted"}, 64'(halted), 64'd0);
    checkOutput({tag, "_instr_count"}, 64'(instr_count), 64'd0);
  endtask

  task automatic checkWb(input string tag, input logic [REG_AW-1:0] dst, input logic [XLEN-1:0] data);
    checkOutput({tag, "_wb_valid"}, 64'(wb_valid), 64'd1);
    checkOutput({tag, "_wb_dst"}, 64'(wb_dst), 64'(dst));
    checkOutput({tag, "_wb_data"}, 64'(wb_data), 64'(data));
  endtask

  initial begin
    int busy_cycles;
    int stray_wb;

    checks     = 0;
    errors     = 0;
    reset      = 1'b1;
    in_valid   = 1'b0;
    in_valid4  = 1'b0;
    in_op      = '0;
    in_src1    = '0;
    in_src2    = '0;
    in_dst     = '0;
    in_imm     = '0;
    dmem_ack   = 1'b0;
    dmem_ack4  = 1'b0;
    dmem_rdata = '0;

    repeat (2) step();
    reset = 1'b0;
    checkResetValues("reset");
    checkOutput("reset_dut4_in_ready", 64'(in_ready4), 64'd1);

    // Back-to-back single-cycle ops, one writeback per cycle.
    applyStimulus(OP_ADD, 32'd5, 32'd7, 5'd3, 16'h0000);
    checkWb("add", 5'd3, 32'd12);
    checkOutput("add_in_ready", 64'(in_ready), 64'd1);
    applyStimulus(OP_ADDI, 32'd10, 32'd0, 5'd4, 16'hFFFF);
    checkWb("addi", 5'd4, 32'd9);
    applyStimulus(OP_LUI, 32'd0, 32'd0, 5'd5, 16'h1234);
    checkWb("lui", 5'd5, 32'h1234_0000);
    step();
    checkOutput("b2b_wb_idle", 64'(wb_valid), 64'd0);
    checkOutput("b2b_count", 64'(instr_count), 64'd3);

    applyStimulus(OP_ORI, 32'h0000_00F0, 32'd0, 5'd1, 16'h000F);
    checkWb("ori", 5'd1, 32'h0000_00FF);
    applyStimulus(OP_MOVEI, 32'd0, 32'd0, 5'd2, 16'h8000);
    checkWb("movei", 5'd2, 32'hFFFF_8000);
    applyStimulus(OP_JAL, 32'd0, 32'd0, 5'd31, 16'h8000);
    checkWb("jal", 5'd31, 32'h0000_8000);
    applyStimulus(OP_MOVE, 32'h0000_0055, 32'd9, 5'd6, 16'h0000);
    checkWb("move", 5'd6, 32'h0000_0055);
    applyStimulus(OP_SLL, 32'd0, 32'd3, 5'd7, 16'h0004);
    checkWb("sll", 5'd7, 32'h0000_0030);
    checkOutput("alu_count", 64'(instr_count), 64'd8);

    // Multiply with one bit per step: 32 busy cycles.
    applyStimulus(OP_MUL, 32'hFFFF_FFFD, 32'd7, 5'd6, 16'h0000);
    busy_cycles = 0;
    stray_wb    = 0;
    while (!in_ready && busy_cycles < 100) begin
      if (wb_valid) stray_wb++;
      busy_cycles++;
      step();
    end
    checkOutput("mul_busy_cycles", 64'(busy_cycles), 64'd32);
    checkOutput("mul_early_wb", 64'(stray_wb), 64'd0);
    checkWb("mul", 5'd6, 32'hFFFF_FFEB);
    checkOutput("mul_count", 64'(instr_count), 64'd9);

    // Same multiply on the four-bits-per-step instance: 8 busy cycles.
    in_op     = OP_MUL;
    in_src1   = 32'hFFFF_FFFD;
    in_src2   = 32'd7;
    in_dst    = 5'd6;
    in_valid4 = 1'b1;
    step();
    in_valid4   = 1'b0;
    busy_cycles = 0;
    while (!in_ready4 && busy_cycles < 100) begin
      busy_cycles++;
      step();
    end
    checkOutput("mul4_busy_cycles", 64'(busy_cycles), 64'd8);
    checkOutput("mul4_wb_valid", 64'(wb_valid4), 64'd1);
    checkOutput("mul4_wb_dst", 64'(wb_dst4), 64'd6);
    checkOutput("mul4_wb_data", 64'(wb_data4), 64'hFFFF_FFEB);
    checkOutput("mul4_count", 64'(instr_count4), 64'd1);
    checkOutput("mul4_no_req", 64'(dmem_req4), 64'd0);
    checkOutput("mul4_halted", 64'(halted4), 64'd0);

    // muli uses the sign-extended immediate as multiplier: 6 * -2.
    applyStimulus(OP_MULI, 32'd6, 32'd0, 5'd9, 16'hFFFE);
    busy_cycles = 0;
    while (!in_ready && busy_cycles < 100) begin
      busy_cycles++;
      step();
    end
    checkOutput("muli_busy_cycles", 64'(busy_cycles), 64'd32);
    checkWb("muli", 5'd9, 32'hFFFF_FFF4);
    checkOutput("muli_count", 64'(instr_count), 64'd10);

    // Store with a slow memory: request and its fields held stable until ack.
    applyStimulus(OP_SW, 32'h0000_0100, 32'h0000_DEAD, 5'd0, 16'h0004);
    for (int i = 0; i < 3; i++) begin
      checkOutput("sw_req", 64'(dmem_req), 64'd1);
      checkOutput("sw_we", 64'(dmem_we), 64'd1);
      checkOutput("sw_addr", 64'(dmem_addr), 64'h104);
      checkOutput("sw_wdata", 64'(dmem_wdata), 64'hDEAD);
      checkOutput("sw_wb_valid", 64'(wb_valid), 64'd0);
      checkOutput("sw_in_ready", 64'(in_ready), 64'd0);
      step();
    end
    dmem_ack = 1'b1;
    step();
    dmem_ack = 1'b0;
    checkOutput("sw_req_drop", 64'(dmem_req), 64'd0);
    checkOutput("sw_no_wb", 64'(wb_valid), 64'd0);
    checkOutput("sw_ready", 64'(in_ready), 64'd1);
    checkOutput("sw_count", 64'(instr_count), 64'd11);

    // Ack with no request outstanding does nothing.
    dmem_ack = 1'b1;
    step();
    dmem_ack = 1'b0;
    checkOutput("stray_ack_wb", 64'(wb_valid), 64'd0);
    checkOutput("stray_ack_count", 64'(instr_count), 64'd11);
    checkOutput("stray_ack_req", 64'(dmem_req), 64'd0);

    // Load from the same address with zero-wait memory.
    applyStimulus(OP_LW, 32'h0000_0100, 32'd0, 5'd7, 16'h0004);
    checkOutput("lw_req", 64'(dmem_req), 64'd1);
    checkOutput("lw_we", 64'(dmem_we), 64'd0);
    checkOutput("lw_addr", 64'(dmem_addr), 64'h104);
    dmem_ack   = 1'b1;
    dmem_rdata = 32'h0000_DEAD;
    step();
    dmem_ack   = 1'b0;
    dmem_rdata = '0;
    checkWb("lw", 5'd7, 32'h0000_DEAD);
    checkOutput("lw_req_drop", 64'(dmem_req), 64'd0);
    checkOutput("lw_count", 64'(instr_count), 64'd12);

    // NOP writes back zero but is not counted; unknown opcode does nothing visible.
    applyStimulus(OP_SLL, 32'd0, 32'd0, 5'd8, 16'h0000);
    checkWb("nop", 5'd8, 32'd0);
    checkOutput("nop_count", 64'(instr_count), 64'd12);
    applyStimulus(5'd7, 32'd1, 32'd1, 5'd9, 16'h0001);
    checkOutput("unknown_wb", 64'(wb_valid), 64'd0);
    checkOutput("unknown_count", 64'(instr_count), 64'd12);
    checkOutput("unknown_ready", 64'(in_ready), 64'd1);

    // Reset five cycles into a multiply abandons it.
    applyStimulus(OP_MUL, 32'd3, 32'd4, 5'd10, 16'h0000);
    repeat (4) step();
    reset = 1'b1;
    step();
    checkResetValues("rst_mul");
    reset = 1'b0;
    applyStimulus(OP_ADD, 32'd1, 32'd2, 5'd11, 16'h0000);
    checkWb("rst_mul_add", 5'd11, 32'd3);
    checkOutput("rst_mul_add_count", 64'(instr_count), 64'd1);
    stray_wb = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (wb_valid) stray_wb++;
    end
    checkOutput("rst_mul_no_late_wb", 64'(stray_wb), 64'd0);
    checkOutput("rst_mul_late_count", 64'(instr_count), 64'd1);

    // Reset while a memory request is outstanding drops it.
    applyStimulus(OP_LW, 32'h0000_0200, 32'd0, 5'd12, 16'h0000);
    checkOutput("rst_mem_req_up", 64'(dmem_req), 64'd1);
    reset = 1'b1;
    step();
    checkResetValues("rst_mem");
    reset    = 1'b0;
    dmem_ack = 1'b1;
    applyStimulus(OP_ADD, 32'd2, 32'd2, 5'd13, 16'h0000);
    dmem_ack = 1'b0;
    checkWb("rst_mem_add", 5'd13, 32'd4);
    checkOutput("rst_mem_add_count", 64'(instr_count), 64'd1);

    // An accept coinciding with reset is discarded.
    in_op    = OP_ADD;
    in_src1  = 32'd9;
    in_src2  = 32'd9;
    in_dst   = 5'd14;
    in_valid = 1'b1;
    reset    = 1'b1;
    step();
    in_valid = 1'b0;
    reset    = 1'b0;
    checkResetValues("rst_accept");
    step();
    checkOutput("rst_accept_no_wb", 64'(wb_valid), 64'd0);
    checkOutput("rst_accept_count", 64'(instr_count), 64'd0);

    // Halt is absorbing; further instructions are refused.
    applyStimulus(OP_HALT, 32'd0, 32'd0, 5'd0, 16'h0000);
    checkOutput("halt_halted", 64'(halted), 64'd1);
    checkOutput("halt_ready", 64'(in_ready), 64'd0);
    checkOutput("halt_count", 64'(instr_count), 64'd1);
    in_op    = OP_ADD;
    in_src1  = 32'd1;
    in_src2  = 32'd1;
    in_dst   = 5'd15;
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      checkOutput("halt_hold_ready", 64'(in_ready), 64'd0);
      checkOutput("halt_hold_halted", 64'(halted), 64'd1);
      checkOutput("halt_hold_wb", 64'(wb_valid), 64'd0);
    end
    in_valid = 1'b0;
    checkOutput("halt_final_count", 64'(instr_count), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/execute_unit.md
# execute_unit

Parametrised execute stage for the in-order CPU core; the successor to the fixed 32-bit execute stage. It accepts one decoded instruction at a time over a valid/ready handshake and executes it:
- single-cycle ALU ops directly;
- multiplies on an iterative shift-add engine;
- loads and stores over a req/ack data-memory port, replacing the bidirectional data bus.

It sits between decode/operand-fetch and register writeback, and also provides the retired-instruction counter and the halt indication.

## Interface
- XLEN, 32: datapath width; must be ≥32 and a multiple of MUL_BITS.
- REG_AW, 5: register address width.
- MUL_BITS, 1: multiplier bits retired per cycle; multiply latency is XLEN/MUL_BITS cycles.
- CNT_W, 32: retired-instruction counter width.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  instruction present.
- in_ready  out  1  unit can accept this cycle.
- in_op  in  5  opcode.
- in_src1, in_src2  in  XLEN  operands, signed.
- in_dst  in  REG_AW  destination register.
- in_imm  in  16  raw immediate.
- wb_valid  out  1  one-cycle writeback strobe.
- wb_dst  out  REG_AW  writeback register.
- wb_data  out  XLEN  writeback value.
- dmem_req  out  1  memory request.
- dmem_we  out  1  1 = store.
- dmem_addr  out  XLEN  byte address.
- dmem_wdata  out  XLEN  store data.
- dmem_ack  in  1  request completion.
- dmem_rdata  in  XLEN  load data, valid with dmem_ack.
- halted  out  1  halt executed.
- instr_count  out  CNT_W  retired non-NOP instructions.

## Operation
- Opcodes:
  - 1 sll: src2 << imm[4:0]
  - 2 addi: src1 + sext(imm)
  - 3 mul: low XLEN bits of src1*src2
  - 4 move: src1
  - 5 movei: sext(imm)
  - 6 add: src1 + src2
  - 9 lw
  - 10 sw
  - 12 halt
  - 13 muli: src1*sext(imm)
  - 14 jal: zext(imm) written to dst
  - 15 ori: src1 | zext(imm)
  - 16 lui: zext(imm) << 16
- Any other opcode: retired, no writeback, not counted.
- Effective address for lw/sw is src1 + sext(imm). dmem_wdata = src2.
- NOP is sll with src2 = 0 and imm = 0. It writes back 0 but is not counted.
- All arithmetic wraps modulo 2^XLEN. instr_count wraps at 2^CNT_W.
- Accept = in_valid & in_ready at a rising edge. Inputs are sampled only at accept.
- FSM states: IDLE, MUL, MEM, HALT.
  - IDLE: accept. Single-cycle op → stay IDLE. mul/muli → MUL. lw/sw → MEM. halt → HALT.
  - MUL: step counter runs from XLEN/MUL_BITS−1 down to 0; at 0 → IDLE with writeback.
  - MEM: dmem_req=1 until dmem_ack sampled high → IDLE. lw writes back dmem_rdata; sw has no writeback.
  - HALT: absorbing state; only reset leaves it.
- in_ready = (state == IDLE).
- instr_count increments in the cycle the instruction's writeback or completion occurs. For halt, it increments on accept.

## Timing
- Reset values: in_ready=1, wb_valid=0, wb_dst=0, wb_data=0, dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0, halted=0, instr_count=0, state=IDLE.
- Single-cycle op accepted at edge N: wb_valid=1 in cycle N+1, for exactly one cycle. Back-to-back issue sustains 1 instruction/cycle.
- mul accepted at edge N: wb_valid in cycle N+XLEN/MUL_BITS+1. in_ready=0 in between.
- lw/sw accepted at edge N: dmem_req rises in cycle N+1. dmem_addr, dmem_we and dmem_wdata are held stable while req=1.
  - If dmem_ack is sampled at edge M: req=0 from cycle M+1, lw wb_valid in cycle M+1, in_ready=1 in cycle M+1.
  - Zero-wait memory (ack in cycle N+1) gives 2-cycle latency.
- dmem_ack while req=0 is ignored.
- halt accepted at edge N: halted=1 and in_ready=0 from cycle N+1 until reset.
- Reset in any state, including mid-multiply or mid-request: at that edge, abandon the operation, drop dmem_req, return all outputs to reset values. No writeback is produced for the abandoned instruction.
- An accept at the same edge as reset is discarded.

## Structure
- Package `cpu_defs_pkg` holds:
  - opcode constants (OP_SLL … OP_LUI);
  - the FSM state enum;
  - sext16/zext16 helper functions.
- Sub-module `iter_mul`: XLEN/MUL_BITS-step shift-add multiplier.
  - Ports: clock, reset, start, a, b, busy, done, product.
  - done is a one-cycle pulse.
- All other logic is inline in execute_unit.

## Test plan
- Reset, then back-to-back add(5,7,dst=3), addi(src1=10, imm=0xFFFF), lui(imm=0x1234) → consecutive wb_valid cycles with 12, 9, 0x12340000. instr_count=3.
- mul(−3, 7) with XLEN=32, MUL_BITS=1 → in_ready low for 32 cycles, wb_data=0xFFFFFFEB. Repeat with MUL_BITS=4 → 8 cycles.
- sw(src1=0x100, imm=4, src2=0xDEAD) with ack delayed 3 cycles → req held with addr=0x104 and wdata=0xDEAD stable for 3 cycles, no wb_valid. lw of the same address returns 0xDEAD in the cycle after ack.
- NOP, then an unknown opcode 7 → no count increment. The NOP produces wb_data=0. The unknown op produces no wb_valid.
- Reset asserted 5 cycles into a mul and again while dmem_req=1 → next cycle: all outputs at reset values, no writeback, and a new add is accepted immediately.
- halt → halted=1, in_ready stays 0 for 20 cycles with in_valid high, instr_count incremented once.
